// File: rtl/prga_fifo_wr_skid_if.sv
// Producer handshake plus FIFO write port seen by prga_fifo_wr_skid.
// slave is the adapter's view; master is the view of whoever surrounds it.
interface prga_fifo_wr_skid_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  up_valid;
  logic                  up_ready;
  logic [DATA_WIDTH-1:0] up_data;
  logic                  full;
  logic                  wr;
  logic [DATA_WIDTH-1:0] din;
  logic [1:0]            level;

  modport slave (
    input  up_valid, up_data, full,
    output up_ready, wr, din, level
  );

  modport master (
    output up_valid, up_data, full,
    input  up_ready, wr, din, level
  );
endinterface

// File: rtl/prga_fifo_wr_skid.sv
// Two-entry write-side skid buffer in front of prga_fifo: every output is a flop,
// so FIFO full never reaches up_ready combinationally, yet one write per cycle is sustained.
//
// Handshake: a producer word transfers at a rising edge when up_valid && up_ready;
// a FIFO write happens at a rising edge when wr && !full. up_data is ignored otherwise.
module prga_fifo_wr_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  prga_fifo_wr_skid_if.slave      bus
);

  // Occupancy state; its encoding is exactly the level count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic                  skid_v_q, skid_v_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  logic out_fire;
  logic up_fire;
  logic out_free;

  assign out_fire = wr_q && !bus.full;
  assign up_fire  = bus.up_valid && ready_q;
  assign out_free = !wr_q || out_fire;

  always_comb begin
    wr_d     = wr_q;
    skid_v_d = skid_v_q;
    din_d    = din_q;
    skid_d   = skid_q;
    state_d  = state_q;

    if (out_free && skid_v_q) begin
      // up_ready is low whenever skid is occupied, so no upstream word competes here.
      wr_d     = 1'b1;
      din_d    = skid_q;
      skid_v_d = 1'b0;
    end else if (out_free && up_fire) begin
      wr_d  = 1'b1;
      din_d = bus.up_data;
    end else if (out_free) begin
      wr_d = 1'b0;
    end else if (up_fire) begin
      skid_v_d = 1'b1;
      skid_d   = bus.up_data;
    end

    unique case ({wr_d, skid_v_d})
      2'b00:   state_d = ST_EMPTY;
      2'b10:   state_d = ST_ONE;
      2'b11:   state_d = ST_TWO;
      default: state_d = ST_ONE;
    endcase

    ready_d = !skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      wr_q     <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b1;
      din_q    <= '0;
      skid_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      skid_v_q <= skid_v_d;
      ready_q  <= ready_d;
      din_q    <= din_d;
      skid_q   <= skid_d;
    end
  end

  assign bus.up_ready = ready_q;
  assign bus.wr       = wr_q;
  assign bus.din      = din_q;
  assign bus.level    = state_q;

endmodule

// File: tb/tb_prga_fifo_wr_skid.sv
// Bench for prga_fifo_wr_skid: directed streaming, stall, idle-gap and reset scenarios
// plus randomised backpressure, checked by a write-port scoreboard.
module tb_prga_fifo_wr_skid;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prga_fifo_wr_skid_if #(.DATA_WIDTH(W)) bus ();

  prga_fifo_wr_skid #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int           n_checks  = 0;
  int           n_fail    = 0;
  int           n_written = 0;
  bit           stream_chk = 1'b0;
  bit           rand_done  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that accepted d.
  task automatic send_word(input logic [W-1:0] d);
    bit accepted;
    accepted = 1'b0;
    bus.up_valid = 1'b1;
    bus.up_data  = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.up_ready === 1'b1) begin
        exp_q.push_back(d);
        @(posedge clk);
        #1;
        accepted = 1'b1;
        break;
      end
    end
    check("accept_timeout", {31'b0, accepted}, 32'd1);
  endtask

  task automatic idle_after_send();
    bus.up_valid = 1'b0;
    bus.up_data  = 'x;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("level_legal", {31'b0, (bus.level != 2'd3) && !(bus.wr && bus.level == 2'd0)}, 32'd1);
      if (stream_chk) begin
        check("stream_up_ready", {31'b0, bus.up_ready}, 32'd1);
        check("stream_level_le1", {31'b0, bus.level <= 2'd1}, 32'd1);
      end
      if (bus.wr === 1'b1 && bus.full === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got din 0x%0h, expected no write", bus.din);
        end else begin
          mon_exp = exp_q.pop_front();
          check("din_order", {24'b0, bus.din}, {24'b0, mon_exp});
          n_written++;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed vectors ----------------
  logic [W-1:0] stream_v[8] = '{8'h5A, 8'hF6, 8'h09, 8'hC4, 8'h81, 8'hE2, 8'hA0, 8'h7A};
  logic [W-1:0] gap_v[4]    = '{8'h3C, 8'h96, 8'hE1, 8'h0F};
  logic [W-1:0] post_v[3]   = '{8'h11, 8'h22, 8'h33};

  initial begin
    int   base;
    time  t0;

    rst_n        = 1'b0;
    bus.up_valid = 1'b0;
    bus.up_data  = '0;
    bus.full     = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr", {31'b0, bus.wr}, 32'd0);
    check("rst_din", {24'b0, bus.din}, 32'd0);
    check("rst_level", {30'b0, bus.level}, 32'd0);
    check("rst_up_ready", {31'b0, bus.up_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // streaming: eight words back-to-back, one accept per cycle
    base       = n_written;
    stream_chk = 1'b1;
    t0         = $time;
    foreach (stream_v[i]) send_word(stream_v[i]);
    check("stream_cycles", ($time - t0) / 10, 32'd8);
    idle_after_send();
    @(posedge clk);
    #1;
    stream_chk = 1'b0;
    check("stream_written", n_written - base, 32'd8);
    check("stream_wr_idle", {31'b0, bus.wr}, 32'd0);
    check("stream_din_hold", {24'b0, bus.din}, 32'h7A);
    drain("stream_drain");

    // stall: full held for five edges while the producer keeps offering
    fork
      begin
        send_word(8'h5A);
        send_word(8'hF6);
        send_word(8'h09);
        idle_after_send();
      end
      begin
        bus.full = 1'b1;
        repeat (2) @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          check("stall_wr", {31'b0, bus.wr}, 32'd1);
          check("stall_din", {24'b0, bus.din}, 32'h5A);
          check("stall_up_ready", {31'b0, bus.up_ready}, 32'd0);
          check("stall_level", {30'b0, bus.level}, 32'd2);
        end
        @(posedge clk);
        #1 bus.full = 1'b0;
        @(negedge clk);
        check("release_din0", {24'b0, bus.din}, 32'h5A);
        @(negedge clk);
        check("release_din1", {24'b0, bus.din}, 32'hF6);
        check("release_up_ready", {31'b0, bus.up_ready}, 32'd1);
        @(negedge clk);
        check("release_din2", {24'b0, bus.din}, 32'h09);
        @(posedge clk);
        #1;
      end
    join
    drain("stall_drain");

    // idle gaps: one word every third cycle
    foreach (gap_v[i]) begin
      send_word(gap_v[i]);
      idle_after_send();
      @(negedge clk);
      check("gap_wr_on", {31'b0, bus.wr}, 32'd1);
      check("gap_level_on", {30'b0, bus.level}, 32'd1);
      check("gap_din_on", {24'b0, bus.din}, {24'b0, gap_v[i]});
      @(negedge clk);
      check("gap_wr_off", {31'b0, bus.wr}, 32'd0);
      check("gap_level_off", {30'b0, bus.level}, 32'd0);
      check("gap_din_hold", {24'b0, bus.din}, {24'b0, gap_v[i]});
      @(posedge clk);
      #1;
    end

    // reset with both entries held and the FIFO full
    bus.full = 1'b1;
    send_word(8'hA1);
    send_word(8'hB2);
    idle_after_send();
    @(negedge clk);
    check("pre_rst_level", {30'b0, bus.level}, 32'd2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_wr", {31'b0, bus.wr}, 32'd0);
    check("mid_rst_level", {30'b0, bus.level}, 32'd0);
    check("mid_rst_up_ready", {31'b0, bus.up_ready}, 32'd1);
    check("mid_rst_din", {24'b0, bus.din}, 32'd0);
    @(posedge clk);
    #1 bus.full = 1'b0;
    foreach (post_v[i]) send_word(post_v[i]);
    idle_after_send();
    drain("post_rst_drain");

    // random backpressure over 1000 words
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          idle_after_send();
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_word(W'($urandom_range(0, 255)));
        end
        idle_after_send();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 bus.full = ($urandom_range(0, 99) < 40);
        end
        bus.full = 1'b0;
      end
    join
    drain("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prga_fifo_wr_skid.md
# prga_fifo_wr_skid

Write-side adapter for `prga_fifo`. It accepts data from a producer over a valid/ready handshake and drives the FIFO write port (`full` / `wr` / `din`). The block is the write-end counterpart of the read-side lookahead buffer. It holds up to two entries so that every output is registered, which breaks the combinational path from the FIFO's `full` to the producer's `ready`, while still sustaining one write per cycle.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: payload width.

Ports:
- `clk` in, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` in, 1 bit: synchronous, active-low reset.
- `up_valid` in, 1 bit: producer has data on `up_data`.
- `up_ready` out, 1 bit: block can accept; registered.
- `up_data` in, `DATA_WIDTH` bits: producer payload.
- `full` in, 1 bit: FIFO full flag; a write is lost unless `full` is 0 at the edge.
- `wr` out, 1 bit: write request to the FIFO; registered; high whenever the output register holds an entry.
- `din` out, `DATA_WIDTH` bits: write data to the FIFO; registered.
- `level` out, 2 bits: entries held (0–2), equal to `wr` + skid-valid.

## Operation

- Storage:
  - Output register `{wr, din}`.
  - Skid register `{skid_v, skid_d}`.
  - `up_ready = !skid_v`, taken directly from the flop.
- Events at each rising edge with `rst_n`=1:
  - `out_fire = wr && !full`.
  - `up_fire = up_valid && up_ready`.
  - `out_free = !wr || out_fire`.
- Next state, checked in order:
  - `out_free && skid_v`: output takes skid; skid empties. `up_fire` cannot occur here because `up_ready` is 0.
  - `out_free && !skid_v && up_fire`: output takes `up_data`.
  - `out_free && !skid_v && !up_fire`: `wr` goes 0 and `din` holds its last value.
  - `!out_free && up_fire`: skid takes `up_data`, so `skid_v` goes 1.
  - `!out_free && !up_fire`: no change.
- Ordering:
  - Strict FIFO order.
  - Each accepted word is presented to the FIFO exactly once.
  - A word is never dropped or duplicated, except on reset.
- `din` changes only when the output register loads. It is stable while `wr`=1 and `full`=1.
- `level` is updated in the same edge as the registers. Legal values are 0, 1 and 2; 3 is unreachable.

## Timing

- Reset (`rst_n`=0 at an edge):
  - `wr`=0, `din`=0, `skid_v`=0, `up_ready`=1, `level`=0.
  - Any held entries are discarded.
  - Reset overrides every other event in the same cycle.
- Latency: a word accepted at edge N has `wr`=1 after edge N. It is written at edge N+1 if `full`=0 there.
- Throughput: one word per cycle with `full`=0 and `up_valid`=1; `up_ready` stays 1 throughout.
- Backpressure:
  - `full` high while the output is occupied: the next accepted word goes to skid, and `up_ready` falls after that edge.
  - At most 2 words are accepted after `full` rises.
- Release: first edge with `full`=0 writes the output word; skid moves to output; `up_ready` returns to 1 after that edge.
- Simultaneous events:
  - `out_fire` together with `up_fire` and skid empty: the output is replaced in the same edge with no bubble.
  - `out_fire` with skid full: skid drains into the output; the upstream word waits one cycle.
- `up_data` is sampled only on `up_fire`. Its value is don't-care otherwise, including X.

## Test plan

- **Streaming:** send 5A F6 09 C4 81 E2 A0 7A back-to-back with `full`=0.
  - FIFO sees `wr`=1 on 8 consecutive edges, starting one cycle after the first handshake.
  - `din` sequence matches; `up_ready` stays 1; `level` ≤ 1.
- **Stall:** `full`=1 for 5 cycles with `up_valid`=1.
  - `wr`=1 and `din`=5A are held; F6 is captured in skid.
  - `up_ready`=0 and `level`=2 during the stall.
  - After `full`=0: 5A then F6 are written on consecutive edges, 09 follows, and nothing is lost.
- **Random backpressure:** `full` and `up_valid` are pseudo-random for 1000 words.
  - Read-back through `prga_fifo` matches the source order exactly.
  - `wr` is never asserted with `level`=0.
- **Idle gaps:** `up_valid` pulses every third cycle.
  - `wr` drops to 0 between words; `din` holds; `level` toggles 0/1.
- **Reset mid-operation:** assert `rst_n`=0 with `level`=2 and `full`=1.
  - After that edge: `wr`=0, `level`=0, `up_ready`=1, `din`=0.
  - A subsequent stream starts clean, with no stale word written.
